imem_loader: RTL and testbench

Boot-time writer for the instruction memory. Receives a length-prefixed byte stream over a valid/ready handshake, packs bytes big-endian into 32-bit instructions, and drives the memory write port at consecutive word indices from 0. Asserts `load_done` when the image is complete; the fetch stage is held in reset until then (`core_rst = rst | ~load_done`).

---
 rtl/imem_loader_if.sv | 26 ++
 rtl/imem_loader.sv | 116 +++++++++++
 tb/tb_imem_loader.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader, with loader status.
interface imem_loader_if #(
    parameter int ADDR_W = 7
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   words_loaded;
    logic              load_done;
    logic              load_err;

    // master: stream source / memory and status observer
    modport master (
        output in_data, in_valid,
        input  in_ready, imem_we, imem_waddr, imem_wdata, words_loaded, load_done, load_err
    );

    // slave: the loader itself
    modport slave (
        input  in_data, in_valid,
        output in_ready, imem_we, imem_waddr, imem_wdata, words_loaded, load_done, load_err
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte stream -> big-endian 32-bit words written from index 0 (IMEM_LOADER_CHECKSUM_EN adds trailing XOR byte).
// Latency: 4th byte of a word accepted at T -> imem_we in cycle T+1; load_done from T+2 (or T+1 after checksum byte).
// Backpressure: none from writes, 1 byte/cycle; in_ready drops only in DONE/ERR or while rst is high.
module imem_loader #(
    parameter int DEPTH  = 101,
    parameter int ADDR_W = 7
) (
    input  logic         clk,
    input  logic         rst,
    imem_loader_if.slave bus
);
    localparam logic [2:0] S_LEN_HI = 3'd0;
    localparam logic [2:0] S_LEN_LO = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CSUM   = 3'd3;
`endif
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    localparam logic [15:0] DEPTH16 = 16'(DEPTH);

    logic [2:0]      state;
    logic [7:0]      len_hi;
    logic [15:0]     word_total;
    logic [1:0]      byte_cnt;
    logic [23:0]     partial;
    logic [ADDR_W:0] word_cnt;
    logic            we_q;
    logic [31:0]     wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]      csum;
`endif

    logic        accept;
    logic        last_word;
    logic [15:0] len_next;

    assign bus.in_ready = ~rst & (state != S_DONE) & (state != S_ERR);
    assign accept       = bus.in_valid & bus.in_ready;
    assign len_next     = {len_hi, bus.in_data};
    // word_cnt is already settled here: writes are at least four cycles apart
    assign last_word    = (16'(word_cnt) + 16'd1) == word_total;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_LEN_HI;
            len_hi     <= 8'd0;
            word_total <= 16'd0;
            byte_cnt   <= 2'd0;
            partial    <= 24'd0;
            word_cnt   <= '0;
            we_q       <= 1'b0;
            wdata_q    <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= 8'd0;
`endif
        end else begin
            we_q <= 1'b0;
            if (we_q) begin
                word_cnt <= word_cnt + (ADDR_W+1)'(1);
            end
            if (accept) begin
                case (state)
                    S_LEN_HI: begin
                        len_hi <= bus.in_data;
                        state  <= S_LEN_LO;
                    end
                    S_LEN_LO: begin
                        word_total <= len_next;
                        if (len_next == 16'd0 || len_next > DEPTH16) begin
                            state <= S_ERR;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                    S_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum <= csum ^ bus.in_data;
`endif
                        // byte counter wraps to 0 after the 4th byte
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            we_q    <= 1'b1;
                            wdata_q <= {partial, bus.in_data};
                            if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state <= S_CSUM;
`else
                                state <= S_DONE;
`endif
                            end
                        end else begin
                            partial <= {partial[15:0], bus.in_data};
                        end
                    end
`ifdef IMEM_LOADER_CHECKSUM_EN
                    S_CSUM: begin
                        state <= (bus.in_data == csum) ? S_DONE : S_ERR;
                    end
`endif
                    default: begin
                    end
                endcase
            end
        end
    end

    // Reset in the write cycle suppresses the strobe; done waits for the final write to retire
    assign bus.imem_we      = we_q & ~rst;
    assign bus.imem_waddr   = word_cnt[ADDR_W-1:0];
    assign bus.imem_wdata   = wdata_q;
    assign bus.words_loaded = word_cnt;
    assign bus.load_done    = (state == S_DONE) & ~we_q;
    assign bus.load_err     = (state == S_ERR);
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: vector table of whole images plus hand-written reset/checksum/depth sequences.
module tb_imem_loader;
    localparam int DEPTH  = 101;
    localparam int ADDR_W = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus();

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [7:0] tb_csum;

    logic [ADDR_W-1:0] wa_q[$];
    logic [31:0]       wd_q[$];

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wa_q.push_back(bus.imem_waddr);
            wd_q.push_back(bus.imem_wdata);
        end
    end

    typedef struct {
        logic [15:0]      len;
        int               nsend;
        logic [3:0][31:0] w;
        bit               gap;
        bit               exp_done;
        bit               exp_err;
        int               exp_writes;
    } vec_t;

    localparam int NV = 7;
    vec_t vec [NV];

    function automatic vec_t mk(input logic [15:0] len, input int nsend,
                                input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                                input bit gap, input bit d, input bit e);
        vec_t v;
        v.len = len; v.nsend = nsend;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = 32'd0;
        v.gap = gap; v.exp_done = d; v.exp_err = e;
        v.exp_writes = d ? nsend : 0;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ready_in_reset", bus.in_ready, 0);
        rst = 1'b0;
        wa_q.delete();
        wd_q.delete();
        #1;
        check("reset_state",
              {bus.in_ready, bus.imem_we, bus.imem_waddr, bus.imem_wdata, bus.words_loaded,
               bus.load_done, bus.load_err},
              {1'b1, 1'b0, 7'd0, 32'd0, 8'd0, 1'b0, 1'b0});
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout byte=%0h ready=%b required=1", b, bus.in_ready);
        end
        @(negedge clk);
        if (gap) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic send_len(input logic [15:0] len, input bit gap);
        tb_csum = 8'd0;
        send_byte(len[15:8], gap);
        send_byte(len[7:0], gap);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int k = 3; k >= 0; k--) begin
            tb_csum = tb_csum ^ w[k*8 +: 8];
            send_byte(w[k*8 +: 8], gap);
        end
    endtask

    // Leaves the bench at the first cycle where load_done must be visible
    task automatic finish_image();
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(tb_csum, 1'b0);
`else
        @(negedge clk);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int nw;
        logic [31:0] ew;

        vec[0] = mk(16'd2,      2, 32'hDEADBEEF, 32'h12345678, 32'h0,        1'b0, 1'b1, 1'b0);
        vec[1] = mk(16'd2,      2, 32'hDEADBEEF, 32'h12345678, 32'h0,        1'b1, 1'b1, 1'b0);
        vec[2] = mk(16'd0,      0, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 1'b1);
        vec[3] = mk(16'h0066,   0, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 1'b1);
        vec[4] = mk(16'h0100,   0, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 1'b1);
        vec[5] = mk(16'd3,      3, 32'h01020304, 32'hA5A5A5A5, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
        vec[6] = mk(16'd1,      1, 32'h00000000, 32'h0,        32'h0,        1'b1, 1'b1, 1'b0);

        for (int i = 0; i < NV; i++) begin
            do_reset();
            send_len(vec[i].len, vec[i].gap);
            for (int k = 0; k < vec[i].nsend; k++) begin
                send_word(vec[i].w[k], vec[i].gap);
            end
            if (vec[i].exp_done) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                send_byte(tb_csum, vec[i].gap);
`else
                if (!vec[i].gap) begin
                    check($sformatf("v%0d_last_we_before_done", i), {bus.imem_we, bus.load_done}, 2'b10);
                    @(negedge clk);
                end
`endif
            end
            check($sformatf("v%0d_done_err", i), {bus.load_done, bus.load_err},
                  {vec[i].exp_done, vec[i].exp_err});

            nw  = wa_q.size();
            bad = 0;
            for (int c = 0; c < 10; c++) begin
                bus.in_valid = 1'b1;
                bus.in_data  = 8'h5A;
                @(negedge clk);
                if (bus.in_ready !== 1'b0 || bus.imem_we !== 1'b0) bad++;
            end
            bus.in_valid = 1'b0;
            check($sformatf("v%0d_post_quiet", i), bad, 0);
            check($sformatf("v%0d_stable", i), {wa_q.size() == nw, bus.load_done, bus.load_err},
                  {1'b1, vec[i].exp_done, vec[i].exp_err});
            check($sformatf("v%0d_nwrites", i), wa_q.size(), vec[i].exp_writes);
            check($sformatf("v%0d_words_loaded", i), bus.words_loaded, vec[i].exp_writes);
            for (int k = 0; k < wa_q.size() && k < vec[i].exp_writes; k++) begin
                check($sformatf("v%0d_w%0d", i, k), {wa_q[k], wd_q[k]}, {7'(k), vec[i].w[k]});
            end
        end

        // Full-depth image: 101 words, last at index 100
        do_reset();
        send_len(16'd101, 1'b0);
        for (int k = 0; k < DEPTH; k++) begin
            send_word((32'(k) * 32'h01010101) ^ 32'hC3000000, 1'b0);
        end
        finish_image();
        bus.in_valid = 1'b0;
        check("depth_done", {bus.load_done, bus.load_err}, 2'b10);
        check("depth_nwrites", wa_q.size(), DEPTH);
        check("depth_words_loaded", bus.words_loaded, DEPTH);
        if (wa_q.size() == DEPTH) begin
            check("depth_last_addr", wa_q[DEPTH-1], 100);
            bad = 0;
            for (int k = 0; k < DEPTH; k++) begin
                ew = (32'(k) * 32'h01010101) ^ 32'hC3000000;
                if (wa_q[k] !== 7'(k) || wd_q[k] !== ew) bad++;
            end
            check("depth_contents", bad, 0);
        end

        // Reset mid-word, then a fresh one-word image
        do_reset();
        send_len(16'd2, 1'b0);
        send_word(32'h01234567, 1'b0);
        send_byte(8'h89, 1'b0);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midreset_cleared", {bus.in_ready, bus.words_loaded, bus.load_done, bus.load_err},
              {1'b1, 8'd0, 1'b0, 1'b0});
        wa_q.delete();
        wd_q.delete();
        send_len(16'd1, 1'b0);
        send_word(32'hCAFEBABE, 1'b0);
        finish_image();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("midreset_done", {bus.load_done, bus.load_err, bus.words_loaded}, {1'b1, 1'b0, 8'd1});
        check("midreset_nwrites", wa_q.size(), 1);
        if (wa_q.size() >= 1) check("midreset_write", {wa_q[0], wd_q[0]}, {7'd0, 32'hCAFEBABE});

        // Reset arriving in the cycle of a pending write suppresses it
        do_reset();
        send_len(16'd1, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        bus.in_data  = 8'h44;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("rst_wins_we", bus.imem_we, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_wins_after", {wa_q.size() == 0, bus.words_loaded, bus.load_done}, {1'b1, 8'd0, 1'b0});

`ifdef IMEM_LOADER_CHECKSUM_EN
        for (int f = 0; f < 2; f++) begin
            do_reset();
            send_len(16'd1, 1'b0);
            send_word(32'h11223344, 1'b0);
            check($sformatf("csum%0d_model", f), tb_csum, 8'h44);
            send_byte(tb_csum ^ 8'(f), 1'b0);
            bus.in_valid = 1'b0;
            check($sformatf("csum%0d_result", f), {bus.load_done, bus.load_err}, (f == 0) ? 2'b10 : 2'b01);
            check($sformatf("csum%0d_write", f), {32'(wa_q.size()), wd_q.size() > 0 ? wd_q[0] : 32'd0},
                  {32'd1, 32'h11223344});
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
